// File: rtl/spi_display_seq_pkg.sv
// Shared definitions for the SPI display initialiser: serialiser state encoding,
// ROM word layout and the helper that unpacks a parameter-supplied ROM image.
package spi_display_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  localparam int WORD_W   = 9;
  localparam int DC_BIT   = 8;
  localparam int DATA_MSB = 7;
  localparam int ROM_MAX  = 64;

  // Word idx of a packed image; word 0 sits in the least significant bits.
  function automatic logic [WORD_W-1:0] init_word(input logic [WORD_W*ROM_MAX-1:0] img,
                                                  input int idx);
    if (idx < 0 || idx >= ROM_MAX) return '0;
    return img[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/spi_display_seq_strobe.sv
// Prescaler: a down-counter that raises step for one clock every DIV+1 clocks.
module spi_display_seq_strobe #(
  parameter int          DIV_WIDTH = 2,
  parameter int unsigned DIV       = 3
) (
  input  logic clock,
  input  logic reset_n,
  output logic step
);

  localparam logic [DIV_WIDTH-1:0] RELOAD = DIV_WIDTH'(DIV);

  logic [DIV_WIDTH-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= RELOAD;
    end else if (r_count == '0) begin
      r_count <= RELOAD;
    end else begin
      r_count <= r_count - 1'b1;
    end
  end

  assign step = (r_count == '0);

endmodule

// File: rtl/spi_display_seq.sv
// SPI display initialiser: plays a ROM of {dc, data} words out once after reset
// as SPI mode-0 bytes, MSB first, with chip select held low across the stream.
module spi_display_seq
  import spi_display_seq_pkg::*;
#(
  parameter int                        DIV_WIDTH = 2,
  parameter int unsigned               DIV       = 3,
  parameter string                     ROM_FILE  = "spi-display.hex",
  parameter int                        ROM_SIZE  = 20,
  parameter logic [WORD_W*ROM_MAX-1:0] ROM_INIT  = '0
) (
  input  logic clock,
  input  logic reset_n,
  output logic spi_cs_n,
  output logic spi_clock,
  output logic spi_dc,
  output logic spi_mosi,
  output logic done
);

  // The address must be able to hold ROM_SIZE itself, which marks "empty".
  localparam int AW    = (ROM_SIZE > 0) ? $clog2(ROM_SIZE + 1) : 1;
  localparam int DEPTH = 1 << AW;

  logic              w_step;
  logic              w_get;
  logic              w_empty;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_mem [DEPTH];

  logic [AW-1:0]         r_addr;
  state_e                r_state;
  logic [DATA_MSB-1:0]   r_shreg;
  logic [2:0]            r_count;
  logic                  r_cs_n;
  logic                  r_sck;
  logic                  r_dc;
  logic                  r_mosi;

  spi_display_seq_strobe #(
    .DIV_WIDTH (DIV_WIDTH),
    .DIV       (DIV)
  ) u_strobe (
    .clock   (clock),
    .reset_n (reset_n),
    .step    (w_step)
  );

  // The parameter image is the ROM content.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign w_mem[i] = init_word(ROM_INIT, i);
  end

  assign w_empty = (r_addr == AW'(ROM_SIZE));
  assign w_word  = w_mem[r_addr];
  assign w_get   = w_step && !w_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_HIGH) && (r_count == 3'd0)));
  assign done    = w_empty && (r_state == ST_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
    end else if (w_get) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_count <= 3'd0;
      r_cs_n  <= 1'b1;
      r_sck   <= 1'b0;
      r_dc    <= 1'b0;
      r_mosi  <= 1'b0;
    end else if (w_step) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_empty) r_state <= ST_LOW;
        end
        ST_LOW: begin
          r_sck   <= 1'b1;
          r_state <= ST_HIGH;
        end
        ST_HIGH: begin
          r_sck <= 1'b0;
          if (r_count != 3'd0) begin
            r_mosi  <= r_shreg[DATA_MSB-1];
            r_shreg <= {r_shreg[DATA_MSB-2:0], 1'b0};
            r_count <= r_count - 3'd1;
            r_state <= ST_LOW;
          end else if (!w_empty) begin
            r_state <= ST_LOW;
          end else begin
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          r_cs_n  <= 1'b1;
          r_mosi  <= 1'b0;
          r_dc    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
      // A fetched word drives its MSB at once; the shift register keeps the rest.
      if (w_get) begin
        r_shreg <= w_word[DATA_MSB-1:0];
        r_dc    <= w_word[DC_BIT];
        r_mosi  <= w_word[DATA_MSB];
        r_cs_n  <= 1'b0;
        r_count <= 3'd7;
      end
    end
  end

  assign spi_cs_n  = r_cs_n;
  assign spi_clock = r_sck;
  assign spi_dc    = r_dc;
  assign spi_mosi  = r_mosi;

endmodule

// File: tb/tb_spi_display_seq.sv
// Bench for spi_display_seq: four ROM images side by side, checked every cycle
// against a step-indexed model of the pin waveform plus hand-computed totals.
module tb_spi_display_seq;
  import spi_display_seq_pkg::*;

  localparam int NI   = 4;
  localparam int FULL = 4 * (16 * 20 + 2) + 40;

  function automatic int n_of(input int sel);
    case (sel)
      0:       return 1;
      1:       return 2;
      2:       return 20;
      default: return 0;
    endcase
  endfunction

  function automatic logic [8:0] tb_word(input int sel, input int i);
    case (sel)
      0:       return (i == 0) ? 9'h1AA : 9'h000;
      1:       return (i == 0) ? 9'h0C3 : ((i == 1) ? 9'h155 : 9'h000);
      2:       return {(i % 3 == 0), 8'(i * 29 + 3)};
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [WORD_W*ROM_MAX-1:0] make_rom(input int sel);
    logic [WORD_W*ROM_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < n_of(sel); i++) r[i*WORD_W +: WORD_W] = tb_word(sel, i);
    return r;
  endfunction

  localparam logic [WORD_W*ROM_MAX-1:0] ROM_A = make_rom(0);
  localparam logic [WORD_W*ROM_MAX-1:0] ROM_B = make_rom(1);
  localparam logic [WORD_W*ROM_MAX-1:0] ROM_C = make_rom(2);
  localparam logic [WORD_W*ROM_MAX-1:0] ROM_D = make_rom(3);

  // Pins {done, cs_n, sck, dc, mosi} after s completed steps: one step loads a
  // word, each bit then spends one step with sck low and one with sck high.
  function automatic logic [4:0] expect_out(input int sel, input int s);
    int n, t, w, p, b;
    logic [8:0] wd;
    n = n_of(sel);
    if (n == 0) return 5'b11000;
    if (s == 0) return 5'b01000;
    if (s <= 16 * n) begin
      t  = s - 1;
      w  = t / 16;
      p  = t % 16;
      b  = 7 - p / 2;
      wd = tb_word(sel, w);
      return {1'b0, 1'b0, 1'(p % 2), wd[8], wd[b]};
    end
    if (s == 16 * n + 1) begin
      wd = tb_word(sel, n - 1);
      return {1'b0, 1'b0, 1'b0, wd[8], wd[0]};
    end
    return 5'b11000;
  endfunction

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic [NI-1:0] cs_n, sck, dc, mosi, done;

  always #5 clock = ~clock;

  spi_display_seq #(.DIV_WIDTH(2), .DIV(3), .ROM_FILE(""), .ROM_SIZE(1), .ROM_INIT(ROM_A)) u_a (
    .clock(clock), .reset_n(reset_n), .spi_cs_n(cs_n[0]), .spi_clock(sck[0]),
    .spi_dc(dc[0]), .spi_mosi(mosi[0]), .done(done[0]));
  spi_display_seq #(.DIV_WIDTH(2), .DIV(3), .ROM_FILE(""), .ROM_SIZE(2), .ROM_INIT(ROM_B)) u_b (
    .clock(clock), .reset_n(reset_n), .spi_cs_n(cs_n[1]), .spi_clock(sck[1]),
    .spi_dc(dc[1]), .spi_mosi(mosi[1]), .done(done[1]));
  spi_display_seq #(.DIV_WIDTH(2), .DIV(3), .ROM_FILE(""), .ROM_SIZE(20), .ROM_INIT(ROM_C)) u_c (
    .clock(clock), .reset_n(reset_n), .spi_cs_n(cs_n[2]), .spi_clock(sck[2]),
    .spi_dc(dc[2]), .spi_mosi(mosi[2]), .done(done[2]));
  spi_display_seq #(.DIV_WIDTH(2), .DIV(3), .ROM_FILE(""), .ROM_SIZE(0), .ROM_INIT(ROM_D)) u_d (
    .clock(clock), .reset_n(reset_n), .spi_cs_n(cs_n[3]), .spi_clock(sck[3]),
    .spi_dc(dc[3]), .spi_mosi(mosi[3]), .done(done[3]));

  int edges = 0;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int rises [NI];
  int cs_rises [NI];
  bit cs_low [NI];
  logic [15:0] cap [NI];
  logic [15:0] dcs [NI];
  logic [7:0]  first_byte [NI];
  logic prev_sck [NI];
  logic prev_cs [NI];
  int gets;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic clear_trk();
    for (int k = 0; k < NI; k++) begin
      rises[k] = 0; cs_rises[k] = 0; cs_low[k] = 1'b0;
      cap[k] = '0; dcs[k] = '0; first_byte[k] = '0;
      prev_sck[k] = 1'b0; prev_cs[k] = 1'b1;
    end
    gets = 0;
  endtask

  task automatic cycle_check();
    @(negedge clock);
    if (reset_n) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("pins u%0d edge %0d", k, edges),
            {27'd0, done[k], cs_n[k], sck[k], dc[k], mosi[k]},
            {27'd0, expect_out(k, edges / 4)});
        if (sck[k] && !prev_sck[k]) begin
          rises[k]++;
          cap[k] = {cap[k][14:0], mosi[k]};
          dcs[k] = {dcs[k][14:0], dc[k]};
          if (rises[k] == 8) first_byte[k] = cap[k][7:0];
        end
        if (cs_n[k] && !prev_cs[k]) cs_rises[k]++;
        if (!cs_n[k]) cs_low[k] = 1'b1;
        prev_sck[k] = sck[k];
        prev_cs[k]  = cs_n[k];
      end
      chk($sformatf("step edge %0d", edges), {31'd0, u_a.u_strobe.step},
          {31'd0, (edges % 4 == 3)});
      if (u_c.w_get) gets++;
    end
  endtask

  task automatic run_until(input int limit);
    for (int g = 0; g < limit + 50 && edges < limit; g++) cycle_check();
    if (edges < limit) chk("run bound", edges, limit);
  endtask

  initial begin
    clear_trk();
    repeat (3) @(negedge clock);
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset pins u%0d", k), {done[k], cs_n[k], sck[k], dc[k], mosi[k]}, 5'b01000);
    chk("reset pins u3", {done[3], cs_n[3], sck[3], dc[3], mosi[3]}, 5'b11000);

    reset_n = 1'b1;
    repeat (3) cycle_check();
    chk("idle before first step A", {cs_n[0], sck[0], mosi[0], done[0]}, 4'b1000);
    chk("idle before first step C", {cs_n[2], sck[2], mosi[2], done[2]}, 4'b1000);
    run_until(FULL);

    chk("A sck rises", rises[0], 8);
    chk("A mosi bits", cap[0], 16'h00AA);
    chk("A dc bits", dcs[0], 16'h00FF);
    chk("A cs_n rises", cs_rises[0], 1);
    chk("A done", done[0], 1'b1);
    chk("B sck rises", rises[1], 16);
    chk("B mosi bits", cap[1], 16'hC355);
    chk("B dc bits", dcs[1], 16'h00FF);
    chk("B cs_n rises", cs_rises[1], 1);
    chk("C sck rises", rises[2], 160);
    chk("C get pulses", gets, 20);
    chk("C addr", u_c.r_addr, 20);
    chk("C cs_n rises", cs_rises[2], 1);
    chk("C done", done[2], 1'b1);
    chk("D sck rises", rises[3], 0);
    chk("D cs_n ever low", cs_low[3], 1'b0);
    chk("D done", done[3], 1'b1);

    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    clear_trk();
    run_until(4 * 41);
    @(posedge clock); #3;
    chk("C cs_n mid byte", cs_n[2], 1'b0);
    chk("C mosi mid byte", mosi[2], 1'b1);
    chk("A done before reset", done[0], 1'b1);
    reset_n = 1'b0;
    #1;
    chk("C async reset pins", {done[2], cs_n[2], sck[2], dc[2], mosi[2]}, 5'b01000);
    chk("A async reset done", done[0], 1'b0);
    chk("C async reset addr", u_c.r_addr, 0);
    @(negedge clock);
    chk("C held in reset", {cs_n[2], sck[2], mosi[2]}, 3'b100);
    @(negedge clock);
    reset_n = 1'b1;
    clear_trk();
    run_until(FULL);

    chk("C replay first byte", first_byte[2], 8'h03);
    chk("C replay sck rises", rises[2], 160);
    chk("C replay get pulses", gets, 20);
    chk("A replay mosi bits", cap[0], 16'h00AA);
    chk("C replay done", done[2], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
